load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 3, byte-address width of the data memory port (2 words).
REQ-002 Parameter READ_LAT, default 2, cycles from memread assertion to valid mem_read_data (range 1..7).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  pipeline request present.
REQ-006 req_ready  output  1  unit can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  0 = byte, 1 = halfword, 2 = word; 3 is reserved.
REQ-009 req_signed  input  1  sign-extend a sub-word load.
REQ-010 req_addr  input  ADDR_W  byte address.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  32  load result, extended to 32 bits.
REQ-014 resp_err  output  1  misaligned or reserved-size request, qualified by resp_valid.
REQ-015 address  output  ADDR_W  memory byte address, always word-aligned.
REQ-016 write_data  output  32  memory store word.
REQ-017 memread  output  1  memory read strobe.
REQ-018 memwrite  output  1  memory write strobe.
REQ-019 read_data  input  32  memory read word, big-endian: byte offset 0 is bits [31:24].

Function
REQ-020 A request is accepted when req_valid and req_ready are both high, and the unit captures all req_* fields in that cycle.
REQ-021 req_ready is high only in IDLE; there is one outstanding request at most.
REQ-022 The FSM has the states IDLE, READ, WRITE, RESP.
REQ-023 Misaligned requests (half with addr[0]=1, word with addr[1:0]!=0) and size 3 go IDLE->RESP with resp_err=1 and resp_rdata=0, and never assert memread or memwrite.
REQ-024 Loads go IDLE->READ; memread stays high for exactly READ_LAT cycles under a down-counter; read_data is sampled in the last READ cycle; then READ->RESP.
REQ-025 Word stores go IDLE->WRITE; memwrite is high for exactly one cycle with write_data=req_wdata; then WRITE->RESP.
REQ-026 Byte and halfword stores perform a read-modify-write, IDLE->READ->WRITE->RESP; only the addressed lanes of the sampled word are replaced by req_wdata[7:0] or [15:0].
REQ-027 memread and memwrite are never high in the same cycle.
REQ-028 address = {req_addr[ADDR_W-1:2], 2'b00} whenever a strobe is high; otherwise it holds its last value.
REQ-029 Load extraction: a byte at offset k is word[31-8k -: 8], and a half at offset k is word[31-8k -: 16].
REQ-030 Sub-word loads are zero-extended when req_signed=0 and sign-extended when req_signed=1; word loads ignore req_signed.
REQ-031 RESP lasts one cycle with resp_valid=1, then returns to IDLE; a new request can be accepted the cycle after RESP.
REQ-032 Latency: load = READ_LAT+1 cycles after acceptance; word store = 2; sub-word store = READ_LAT+2; error = 1.
REQ-033 resp_rdata is 0 for stores and holds its value outside RESP.

Reset
REQ-034 While reset is high, the state goes to IDLE; the counter, memread, memwrite, resp_valid and resp_err are cleared to 0; resp_rdata, write_data and address are cleared to 0.
REQ-035 Reset asserted mid-operation aborts the request in the next cycle with no response; a WRITE cycle coinciding with reset does not assert memwrite.
REQ-036 req_ready is 0 during reset and is 1 in the first cycle after reset deasserts.

Structure
REQ-037 A shared package lsu_pkg holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-038 Lane extract/extend and store-merge logic is a combinational sub-module, lsu_lane_align, instantiated once.

Verification
REQ-039 Memory word0=0x8899AABB, READ_LAT=2; load byte signed at addr 1 -> memread high for 2 cycles, resp_rdata=0xFFFFFF99, resp_valid 3 cycles after acceptance.
REQ-040 Same memory; load half unsigned at addr 2 -> resp_rdata=0x0000AABB; the same request with req_signed=1 -> 0xFFFFAABB.
REQ-041 Store byte 0x12 at addr 6 with word1=0x00000000 -> one read, then memwrite with address=4 and write_data=0x00001200; a later word load at 4 -> 0x00001200.
REQ-042 Store word 0xDEADBEEF at addr 0 -> memwrite for exactly 1 cycle, memread never high, resp_valid 2 cycles after acceptance.
REQ-043 Half load at addr 3 and size 3 at addr 0 -> resp_err=1 in the next cycle, no strobes.
REQ-044 Reset asserted in the second READ cycle of a sub-word store -> no memwrite, no resp_valid, req_ready=1 after reset; back-to-back requests are accepted the cycle after each RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the alignment rule used to reject requests before touching memory.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } lsu_size_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  // True for the reserved size or any access not aligned to its own width.
  function automatic logic bad_request(input logic [1:0] size, input logic [1:0] offset);
    case (lsu_size_t'(size))
      SZ_BYTE: bad_request = 1'b0;
      SZ_HALF: bad_request = offset[0];
      SZ_WORD: bad_request = (offset != 2'b00);
      default: bad_request = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request/response handshake plus data-memory port of the LSU.
interface lsu_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] address;
  logic [31:0]       write_data;
  logic              memread;
  logic              memwrite;
  logic [31:0]       read_data;

  // Pipeline and memory side (drives requests, supplies memory read data).
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err, address, write_data, memread, memwrite
  );

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, read_data,
    output req_ready, resp_valid, resp_rdata, resp_err, address, write_data, memread, memwrite
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane handling for a big-endian 32-bit word: extracts and extends
// sub-word loads, and merges sub-word store data into a fetched word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  lsu_size_t   size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] lane_ins;

  // Offset 0 is the most significant byte, so the right-shift is (3-k) bytes.
  always_comb begin
    shamt     = '0;
    load_data = word;
    lane_mask = '1;
    lane_ins  = wdata;
    case (size)
      SZ_BYTE: shamt = {~offset, 3'b000};
      SZ_HALF: shamt = {~offset[1], 4'b0000};
      default: shamt = '0;
    endcase
    shifted = word >> shamt;
    case (size)
      SZ_BYTE: begin
        load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << shamt;
        lane_ins  = {24'h0, wdata[7:0]} << shamt;
      end
      SZ_HALF: begin
        load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << shamt;
        lane_ins  = {16'h0, wdata[15:0]} << shamt;
      end
      default: begin
        load_data = word;
        lane_mask = '1;
        lane_ins  = wdata;
      end
    endcase
    merge_data = (word & ~lane_mask) | (lane_ins & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: loads, word stores, read-modify-write
// sub-word stores and immediate error responses for bad requests.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned READ_LAT = 2
) (
  input logic   clk,
  input logic   reset,
  lsu_if.slave  bus
);

  localparam logic [2:0] CNT_LAST = 3'(READ_LAT - 1);

  lsu_state_t  state;
  logic [2:0]  cnt;
  logic        write_q;
  logic        signed_q;
  lsu_size_t   size_q;
  logic [1:0]  offset_q;
  logic [31:0] wdata_q;
  logic        memwrite_q;
  logic [31:0] load_data;
  logic [31:0] merge_data;
  logic        accept;

  assign bus.req_ready = (state == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  // Qualified by reset so a WRITE cycle that meets reset never strobes memory.
  assign bus.memwrite  = memwrite_q && !reset;

  lsu_lane_align u_lane_align (
    .word       (bus.read_data),
    .size       (size_q),
    .offset     (offset_q),
    .sign_ext   (signed_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  // Control FSM with registered strobes and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      cnt            <= '0;
      write_q        <= 1'b0;
      signed_q       <= 1'b0;
      size_q         <= SZ_BYTE;
      offset_q       <= '0;
      wdata_q        <= '0;
      memwrite_q     <= 1'b0;
      bus.memread    <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      bus.write_data <= '0;
      bus.address    <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      memwrite_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            write_q  <= bus.req_write;
            signed_q <= bus.req_signed;
            size_q   <= lsu_size_t'(bus.req_size);
            offset_q <= bus.req_addr[1:0];
            wdata_q  <= bus.req_wdata;
            if (bad_request(bus.req_size, bus.req_addr[1:0])) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              bus.resp_err <= 1'b0;
              bus.address  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              if (bus.req_write && lsu_size_t'(bus.req_size) == SZ_WORD) begin
                state          <= WRITE;
                memwrite_q     <= 1'b1;
                bus.write_data <= bus.req_wdata;
              end else begin
                state       <= READ;
                bus.memread <= 1'b1;
                cnt         <= CNT_LAST;
              end
            end
          end
        end
        READ: begin
          if (cnt == 3'd0) begin
            bus.memread <= 1'b0;
            if (write_q) begin
              state          <= WRITE;
              memwrite_q     <= 1'b1;
              bus.write_data <= merge_data;
            end else begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_rdata <= load_data;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WRITE: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a two-word memory model.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic reset;

  lsu_if #(.ADDR_W(3)) bus ();

  load_store_unit #(.ADDR_W(3), .READ_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [2] = '{32'h8899AABB, 32'h00000000};

  always @(posedge clk) begin
    if (bus.memwrite) mem[bus.address[2]] <= bus.write_data;
  end

  always_comb bus.read_data = bus.memread ? mem[bus.address[2]] : 32'h0;

  int unsigned rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, overlap = 0, misal = 0;
  logic [2:0]  last_wa = '0;
  logic [31:0] last_wd = '0;

  always @(negedge clk) begin
    if (bus.memread) rd_cnt <= rd_cnt + 1;
    if (bus.memwrite) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= bus.address;
      last_wd <= bus.write_data;
    end
    if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
    if (bus.memread && bus.memwrite) overlap <= overlap + 1;
    if ((bus.memread || bus.memwrite) && bus.address[1:0] != 2'b00) misal <= misal + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  int unsigned r_lat, r_rd, r_wr;
  logic [31:0] r_rdata;
  logic        r_err, r_ready;

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [2:0] a, input logic [31:0] wd);
    int unsigned rd0, wr0;
    @(negedge clk);
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    r_ready        = bus.req_ready;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rd0     = rd_cnt;
    wr0     = wr_cnt;
    r_lat   = 0;
    r_rdata = 'x;
    r_err   = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        r_lat   = i;
        r_rdata = bus.resp_rdata;
        r_err   = bus.resp_err;
        break;
      end
    end
    @(posedge clk);
    #1;
    r_rd = rd_cnt - rd0;
    r_wr = wr_cnt - wr0;
  endtask

  initial begin
    int unsigned wr0, rv0;
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    chk("rst_strobes", {30'b0, bus.memread, bus.memwrite}, 32'd0);
    chk("rst_resp", {30'b0, bus.resp_valid, bus.resp_err}, 32'd0);
    chk("rst_rdata", bus.resp_rdata, 32'd0);
    chk("rst_wdata", bus.write_data, 32'd0);
    chk("rst_addr", {29'b0, bus.address}, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);

    // Signed byte load at 1 from 0x8899AABB
    do_req(1'b0, 2'd0, 1'b1, 3'd1, 32'h0);
    chk("lb_s1_ready", {31'b0, r_ready}, 32'd1);
    chk("lb_s1_data", r_rdata, 32'hFFFFFF99);
    chk("lb_s1_lat", r_lat, 32'd3);
    chk("lb_s1_rd", r_rd, 32'd2);
    chk("lb_s1_err", {31'b0, r_err}, 32'd0);

    // Half loads at 2, unsigned then signed
    do_req(1'b0, 2'd1, 1'b0, 3'd2, 32'h0);
    chk("lh_u2_ready", {31'b0, r_ready}, 32'd1);
    chk("lh_u2_data", r_rdata, 32'h0000AABB);
    do_req(1'b0, 2'd1, 1'b1, 3'd2, 32'h0);
    chk("lh_s2_data", r_rdata, 32'hFFFFAABB);
    do_req(1'b0, 2'd0, 1'b0, 3'd0, 32'h0);
    chk("lb_u0_data", r_rdata, 32'h00000088);
    do_req(1'b0, 2'd0, 1'b1, 3'd3, 32'h0);
    chk("lb_s3_data", r_rdata, 32'hFFFFFFBB);

    // Byte store 0x12 at 6 into zero word1 (upper wdata bits must be ignored)
    do_req(1'b1, 2'd0, 1'b0, 3'd6, 32'hABCDEF12);
    chk("sb6_lat", r_lat, 32'd4);
    chk("sb6_rd", r_rd, 32'd2);
    chk("sb6_wr", r_wr, 32'd1);
    chk("sb6_addr", {29'b0, last_wa}, 32'd4);
    chk("sb6_wdata", last_wd, 32'h00001200);
    chk("sb6_rdata", r_rdata, 32'd0);
    do_req(1'b0, 2'd2, 1'b1, 3'd4, 32'h0);
    chk("lw4_data", r_rdata, 32'h00001200);
    chk("lw4_lat", r_lat, 32'd3);

    // Half store 0x5678 at 4 merges into 0x00001200
    do_req(1'b1, 2'd1, 1'b0, 3'd4, 32'hFFFF5678);
    chk("sh4_wdata", last_wd, 32'h56781200);
    chk("sh4_lat", r_lat, 32'd4);
    do_req(1'b0, 2'd1, 1'b1, 3'd4, 32'h0);
    chk("lh_s4_data", r_rdata, 32'h00005678);
    do_req(1'b0, 2'd0, 1'b1, 3'd5, 32'h0);
    chk("lb_s5_data", r_rdata, 32'h00000078);

    // Word store at 0
    do_req(1'b1, 2'd2, 1'b0, 3'd0, 32'hDEADBEEF);
    chk("sw0_lat", r_lat, 32'd2);
    chk("sw0_rd", r_rd, 32'd0);
    chk("sw0_wr", r_wr, 32'd1);
    chk("sw0_wdata", last_wd, 32'hDEADBEEF);
    chk("sw0_rdata", r_rdata, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 3'd0, 32'h0);
    chk("lw0_data", r_rdata, 32'hDEADBEEF);

    // Error requests
    do_req(1'b0, 2'd1, 1'b0, 3'd3, 32'h0);
    chk("err_h3_lat", r_lat, 32'd1);
    chk("err_h3_err", {31'b0, r_err}, 32'd1);
    chk("err_h3_strobes", r_rd + r_wr, 32'd0);
    chk("err_h3_rdata", r_rdata, 32'd0);
    do_req(1'b1, 2'd3, 1'b0, 3'd0, 32'h12345678);
    chk("err_sz3_lat", r_lat, 32'd1);
    chk("err_sz3_err", {31'b0, r_err}, 32'd1);
    chk("err_sz3_strobes", r_rd + r_wr, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 3'd2, 32'h0);
    chk("err_w2_err", {31'b0, r_err}, 32'd1);

    // Reset during the second READ cycle of a byte store
    @(negedge clk);
    bus.req_write  = 1'b1;
    bus.req_size   = 2'd0;
    bus.req_signed = 1'b0;
    bus.req_addr   = 3'd1;
    bus.req_wdata  = 32'h00000077;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wr0 = wr_cnt;
    rv0 = resp_cnt;
    @(negedge clk);
    chk("abort_read1", {31'b0, bus.memread}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready_in_rst", {31'b0, bus.req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", {31'b0, bus.req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    chk("abort_no_write", wr_cnt - wr0, 32'd0);
    chk("abort_no_resp", resp_cnt - rv0, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 3'd0, 32'h0);
    chk("abort_mem_kept", r_rdata, 32'hDEADBEEF);
    chk("abort_next_ready", {31'b0, r_ready}, 32'd1);

    chk("no_overlap", overlap, 32'd0);
    chk("strobe_addr_aligned", misal, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
